// File: rtl/vg64_pkg.sv
`default_nettype none
// ============================================================================
//  vg64_pkg
//  Shared register offsets, token bit positions and write-record type.
//  Rev 1.0
// ============================================================================
package vg64_pkg;

  localparam logic [1:0] TOKEN_OFS   = 2'd0;
  localparam logic [1:0] LSB_OFS     = 2'd1;
  localparam logic [1:0] MSB_OFS     = 2'd2;
  localparam logic [1:0] OPERAND_OFS = 2'd3;

  localparam int BANK_BIT    = 0;
  localparam int AUTOINC_BIT = 5;
  localparam int RES_BIT     = 6;
  localparam int SCREEN_BIT  = 7;

  localparam int REC_W = 25;

  typedef struct packed {
    logic        bank;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_rec_t;

  function automatic logic [16:0] rec_sram_addr(input wr_rec_t r);
    return {r.bank, r.addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vg64_sync_fifo.sv
`default_nettype none
// ============================================================================
//  vg64_sync_fifo
//  Show-ahead single-clock FIFO; full-with-pop accepts the push.
//  Rev 1.0
// ============================================================================
module vg64_sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_push_ok,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] C_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   C_CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == C_DEPTH);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];

  // A pop on an empty FIFO is ignored; a full FIFO still takes a push if it pops.
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_push_ok = w_push_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/c64_write_queue.sv
`default_nettype none
// ============================================================================
//  c64_write_queue
//  Decodes C64 $DE00-$DE03 writes and queues framebuffer write records.
//  Rev 1.0
// ============================================================================
module c64_write_queue
  import vg64_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hDE00,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                          clk100,
  input  logic                          rst,
  input  logic                          i_64clk,
  input  logic                          i_64rw,
  input  logic [15:0]                   i_64addr,
  input  logic [7:0]                    i_64data,
  output logic [7:0]                    o_token,
  output logic                          o_wr_valid,
  output logic [16:0]                   o_wr_addr,
  output logic [7:0]                    o_wr_data,
  input  logic                          i_wr_ready,
  output logic                          o_full,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sn_d;
  logic                   r_cap_rw;
  logic [15:0]            r_cap_addr;
  logic [7:0]             r_cap_data;
  logic [7:0]             r_token;
  logic [15:0]            r_ptr;
  logic                   r_overflow;

  logic                   w_s1;
  logic                   w_sn;
  logic                   w_strobe;
  logic [15:0]            w_delta;
  logic                   w_hit;
  logic                   w_wr_token;
  logic                   w_wr_lsb;
  logic                   w_wr_msb;
  logic                   w_push;
  logic                   w_push_ok;
  logic                   w_empty;
  wr_rec_t                w_push_rec;
  wr_rec_t                w_head_rec;

  assign w_s1     = r_sync[0];
  assign w_sn     = r_sync[SYNC_STAGES-1];
  assign w_strobe = w_sn & ~r_sn_d;

  // Offset relative to the base so any base alignment decodes correctly.
  assign w_delta    = r_cap_addr - BASE_ADDR;
  assign w_hit      = w_strobe & ~r_cap_rw & (w_delta[15:2] == 14'd0);
  assign w_wr_token = w_hit & (w_delta[1:0] == TOKEN_OFS);
  assign w_wr_lsb   = w_hit & (w_delta[1:0] == LSB_OFS);
  assign w_wr_msb   = w_hit & (w_delta[1:0] == MSB_OFS);
  assign w_push     = w_hit & (w_delta[1:0] == OPERAND_OFS);

  assign w_push_rec.bank = r_token[BANK_BIT];
  assign w_push_rec.addr = r_ptr;
  assign w_push_rec.data = r_cap_data;

  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      r_sync     <= '0;
      r_sn_d     <= 1'b0;
      r_cap_rw   <= 1'b1;
      r_cap_addr <= '0;
      r_cap_data <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_64clk};
      r_sn_d <= w_sn;
      if (w_s1) begin
        r_cap_rw   <= i_64rw;
        r_cap_addr <= i_64addr;
        r_cap_data <= i_64data;
      end
    end
  end

  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      r_token    <= '0;
      r_ptr      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_token) begin
        r_token    <= r_cap_data;
        r_overflow <= 1'b0;
      end
      if (w_wr_lsb) begin
        r_ptr[7:0] <= r_cap_data;
      end
      if (w_wr_msb) begin
        r_ptr[15:8] <= r_cap_data;
      end
      // A dropped push neither advances the pointer nor clears the sticky flag.
      if (w_push && w_push_ok && r_token[AUTOINC_BIT]) begin
        r_ptr <= r_ptr + 16'd1;
      end
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  vg64_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk100),
    .rst_n     (rst),
    .i_push    (w_push),
    .i_din     (w_push_rec),
    .i_pop     (i_wr_ready),
    .o_dout    (w_head_rec),
    .o_empty   (w_empty),
    .o_full    (o_full),
    .o_push_ok (w_push_ok),
    .o_count   (o_count)
  );

  assign o_token    = r_token;
  assign o_wr_valid = ~w_empty;
  assign o_wr_addr  = rec_sram_addr(w_head_rec);
  assign o_wr_data  = w_head_rec.data;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_c64_write_queue.sv
`default_nettype none
// ============================================================================
//  tb_c64_write_queue
//  Scoreboard bench: directed C64 bus cycles, monitor checks popped records.
//  Rev 1.0
// ============================================================================
module tb_c64_write_queue;

  logic        clk100;
  logic        rst;
  logic        i_64clk;
  logic        i_64rw;
  logic [15:0] i_64addr;
  logic [7:0]  i_64data;
  logic [7:0]  o_token;
  logic        o_wr_valid;
  logic [16:0] o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        i_wr_ready;
  logic        o_full;
  logic        o_overflow;
  logic [3:0]  o_count;

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q[$];
  logic        last_pre_valid;
  logic        last_post_valid;

  c64_write_queue #(
    .BASE_ADDR   (16'hDE00),
    .FIFO_DEPTH  (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk100     (clk100),
    .rst        (rst),
    .i_64clk    (i_64clk),
    .i_64rw     (i_64rw),
    .i_64addr   (i_64addr),
    .i_64data   (i_64data),
    .o_token    (o_token),
    .o_wr_valid (o_wr_valid),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .i_wr_ready (i_wr_ready),
    .o_full     (o_full),
    .o_overflow (o_overflow),
    .o_count    (o_count)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever the sequencer takes the head, compare it with the oldest expected record.
  initial begin
    forever begin
      @(negedge clk100);
      #1;
      if (rst && o_wr_valid && i_wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h/%0h expected none", o_wr_addr, o_wr_data);
        end else begin
          logic [24:0] e;
          e = exp_q.pop_front();
          chk("pop_addr", {15'd0, o_wr_addr}, {15'd0, e[24:8]});
          chk("pop_data", {24'd0, o_wr_data}, {24'd0, e[7:0]});
        end
      end
    end
  end

  // One PHI2 bus cycle; optionally asserts i_wr_ready only in the strobe cycle.
  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                           input logic pop_at_strobe);
    @(negedge clk100);
    i_64addr = a;
    i_64data = d;
    i_64rw   = rw;
    i_64clk  = 1'b0;
    repeat (3) @(negedge clk100);
    i_64clk = 1'b1;
    repeat (2) @(negedge clk100);
    last_pre_valid = o_wr_valid;
    if (pop_at_strobe) i_wr_ready = 1'b1;
    @(negedge clk100);
    i_wr_ready = 1'b0;
    last_post_valid = o_wr_valid;
    repeat (3) @(negedge clk100);
    i_64clk = 1'b0;
    repeat (3) @(negedge clk100);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_cycle(a, d, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    @(negedge clk100);
    i_wr_ready = 1'b1;
    repeat (n) @(negedge clk100);
    i_wr_ready = 1'b0;
    @(negedge clk100);
  endtask

  initial begin
    rst        = 1'b0;
    i_64clk    = 1'b0;
    i_64rw     = 1'b1;
    i_64addr   = 16'h0000;
    i_64data   = 8'h00;
    i_wr_ready = 1'b0;
    repeat (3) @(negedge clk100);
    chk("rst_valid", {31'd0, o_wr_valid}, 32'd0);
    chk("rst_addr", {15'd0, o_wr_addr}, 32'd0);
    chk("rst_count", {28'd0, o_count}, 32'd0);
    chk("rst_token", {24'd0, o_token}, 32'd0);
    chk("rst_flags", {30'd0, o_full, o_overflow}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk100);

    // Basic write: token bank=1, autoinc on, pointer $1234, operand $AA
    wr(16'hDE00, 8'h21);
    wr(16'hDE01, 8'h34);
    wr(16'hDE02, 8'h12);
    exp_q.push_back({17'h11234, 8'hAA});
    wr(16'hDE03, 8'hAA);
    chk("lat_pre_valid", {31'd0, last_pre_valid}, 32'd0);
    chk("lat_post_valid", {31'd0, last_post_valid}, 32'd1);
    chk("t1_addr", {15'd0, o_wr_addr}, 32'h11234);
    chk("t1_data", {24'd0, o_wr_data}, 32'hAA);
    chk("t1_count", {28'd0, o_count}, 32'd1);
    chk("t1_token", {24'd0, o_token}, 32'h21);
    drain(3);
    chk("t1_drained", {28'd0, o_count}, 32'd0);

    // Autoinc across the 16-bit wrap, bank stays 1
    wr(16'hDE01, 8'hFF);
    wr(16'hDE02, 8'hFF);
    exp_q.push_back({17'h1FFFF, 8'h01});
    wr(16'hDE03, 8'h01);
    exp_q.push_back({17'h10000, 8'h02});
    wr(16'hDE03, 8'h02);
    chk("t2_count", {28'd0, o_count}, 32'd2);
    drain(4);
    chk("t2_drained", {28'd0, o_count}, 32'd0);

    // Overflow: bank 0, pointer $0100, nine operands into an 8-deep FIFO
    wr(16'hDE00, 8'h20);
    wr(16'hDE01, 8'h00);
    wr(16'hDE02, 8'h01);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({17'h00100 + 17'(i), 8'h40 + 8'(i)});
      wr(16'hDE03, 8'h40 + 8'(i));
    end
    chk("t3_full", {31'd0, o_full}, 32'd1);
    chk("t3_count", {28'd0, o_count}, 32'd8);
    chk("t3_overflow", {31'd0, o_overflow}, 32'd1);
    wr(16'hDE00, 8'h20);
    chk("t3_ovf_clear", {31'd0, o_overflow}, 32'd0);

    // Full with simultaneous push and pop; pointer must be $0108 after 8 increments
    exp_q.push_back({17'h00108, 8'h51});
    bus_cycle(16'hDE03, 8'h51, 1'b0, 1'b1);
    chk("t4_count", {28'd0, o_count}, 32'd8);
    chk("t4_overflow", {31'd0, o_overflow}, 32'd0);
    chk("t4_full", {31'd0, o_full}, 32'd1);
    drain(10);
    chk("t4_drained", {28'd0, o_count}, 32'd0);

    // Read cycle and out-of-range write are ignored
    bus_cycle(16'hDE03, 8'h99, 1'b1, 1'b0);
    wr(16'hDE04, 8'h77);
    chk("t5_valid", {31'd0, o_wr_valid}, 32'd0);
    chk("t5_token", {24'd0, o_token}, 32'h20);
    exp_q.push_back({17'h00109, 8'h60});
    wr(16'hDE03, 8'h60);
    chk("t5_ptr_kept", {15'd0, o_wr_addr}, 32'h00109);

    // Reset mid-PHI2 with three records queued
    wr(16'hDE03, 8'h61);
    wr(16'hDE03, 8'h62);
    chk("t6_count_pre", {28'd0, o_count}, 32'd3);
    @(negedge clk100);
    i_64addr = 16'hDE03;
    i_64rw   = 1'b1;
    i_64clk  = 1'b1;
    @(negedge clk100);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", {31'd0, o_wr_valid}, 32'd0);
    chk("t6_addr_data", {7'd0, o_wr_addr, o_wr_data}, 32'd0);
    chk("t6_count", {28'd0, o_count}, 32'd0);
    chk("t6_token", {24'd0, o_token}, 32'd0);
    exp_q.delete();
    @(negedge clk100);
    rst = 1'b1;
    repeat (4) @(negedge clk100);
    i_64clk = 1'b0;
    repeat (3) @(negedge clk100);
    exp_q.push_back({17'h00000, 8'h77});
    wr(16'hDE03, 8'h77);
    chk("t6_post_count", {28'd0, o_count}, 32'd1);
    wr(16'hDE00, 8'h01);
    exp_q.push_back({17'h10000, 8'h88});
    wr(16'hDE03, 8'h88);
    chk("t6_post_count2", {28'd0, o_count}, 32'd2);
    drain(4);
    chk("end_count", {28'd0, o_count}, 32'd0);
    chk("end_queue", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/c64_write_queue.md
Name: c64_write_queue

Overview:
- Upstream stage of the 640x480 mono SRAM pixel/write sequencer.
- Decodes C64 cartridge-port register writes at $DE00-$DE03 and synchronises them into the clk100 domain.
- Queues framebuffer write requests (17-bit SRAM address + data) in a small FIFO.
- Presents them to the sequencer over a valid/ready handshake, replacing the single-entry wip flag so back-to-back 6510 writes are never lost.

Parameters:
- BASE_ADDR, 16'hDE00, C64 address of the token register; lsb/msb/operand registers follow at +1/+2/+3.
- FIFO_DEPTH, 8, write-record entries; power of two, 2..32.
- SYNC_STAGES, 2, flip-flops in the i_64clk synchroniser, minimum 2.

Ports:
- clk100  in  1  onboard 100 MHz clock; sole clock of the block.
- rst  in  1  reset from C64; asynchronous, active-low.
- i_64clk  in  1  6510 PHI2, asynchronous to clk100.
- i_64rw  in  1  C64 R/W (0 = write).
- i_64addr  in  16  C64 address bus.
- i_64data  in  8  C64 data bus.
- o_token  out  8  token register (bit0 = bank, bit5 = autoinc enable, bit6 = 320/640, bit7 = screen on).
- o_wr_valid  out  1  FIFO head holds a write record.
- o_wr_addr  out  17  head SRAM address, {bank, addr[15:0]}.
- o_wr_data  out  8  head operand byte.
- i_wr_ready  in  1  sequencer accepts the head this cycle.
- o_full  out  1  FIFO full.
- o_overflow  out  1  sticky: a push was dropped.
- o_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - o_token=0, pointer=0, FIFO empty.
  - o_wr_valid=0, o_wr_addr=0, o_wr_data=0.
  - o_full=0, o_overflow=0, o_count=0, synchroniser cleared.
  - Reset mid-operation discards all queued records.
- PHI2 synchroniser:
  - i_64clk passes through SYNC_STAGES flops; stage 1 output is s1, final stage output is sN.
  - Capture registers load i_64rw/i_64addr/i_64data every clk100 cycle in which s1=1, and hold when s1=0.
  - Bus-cycle end is detected when sN=1 and the previous sN=0 for exactly one cycle. This pulse is "strobe".
- Decode, on strobe with captured rw=0:
  - BASE_ADDR: token <= data; o_overflow cleared.
  - BASE_ADDR+1: pointer[7:0] <= data.
  - BASE_ADDR+2: pointer[15:8] <= data.
  - BASE_ADDR+3: push record {token[0], pointer, data}. If token[5]=1 and the push is accepted, pointer <= pointer+1, 16-bit wrap ($FFFF -> $0000), bank bit unchanged.
  - Any other address, or rw=1: no effect. Reads are not served by this block.
- FIFO:
  - Show-ahead: o_wr_addr/o_wr_data always reflect the head; o_wr_valid = not empty.
  - Pop when o_wr_valid & i_wr_ready. i_wr_ready while empty is ignored.
  - Latency: record is visible on o_wr_valid the cycle after strobe (1 clk100).
  - Full, push only: record dropped, o_overflow <= 1, pointer not incremented, count unchanged.
  - Full with simultaneous push and pop: both accepted, count unchanged, no overflow.
  - Empty with simultaneous push and pop: the pop is ignored and the push is accepted (count 1).
  - o_full = (count == FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH.
- Token written in the same strobe as nothing else; a token write affects the bank of subsequent pushes only, never of already-queued records.

Decomposition:
- vg64_pkg holds:
  - register offsets TOKEN_OFS=0, LSB_OFS=1, MSB_OFS=2, OPERAND_OFS=3;
  - token bit indices BANK_BIT=0, AUTOINC_BIT=5, RES_BIT=6, SCREEN_BIT=7;
  - the 25-bit write-record typedef {bank, addr[15:0], data[7:0]}.
- One sub-module, vg64_sync_fifo: parameterised show-ahead FIFO with push/pop/full/empty/count. It also sits behind the block's own overflow logic.

Test Plan:
- Write $DE00=$21, $DE01=$34, $DE02=$12, $DE03=$AA, with i_wr_ready=0 -> o_wr_valid 1 clk100 after the 4th strobe, o_wr_addr=17'h11234, o_wr_data=$AA, o_count=1.
- Autoinc on, pointer=$FFFF, two writes to $DE03 ($01, $02) -> records at 17'h1FFFF then 17'h10000, with bank held.
- i_wr_ready=0, 9 operand writes with FIFO_DEPTH=8 -> o_full=1, 9th dropped, o_overflow=1, pointer advanced 8 times. A subsequent $DE00 write clears o_overflow.
- FIFO full, and the operand strobe lands on the same cycle as i_wr_ready=1 -> count stays 8, new record at tail, o_overflow stays 0.
- rst pulled low for 1 cycle with 3 records queued and PHI2 mid-cycle -> all outputs 0 immediately. The next complete bus write decodes normally.
- Read cycle (rw=1) to $DE03 and write to $DE04 -> no push, token and pointer unchanged.
